// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port and a load/store data port, with a configurable number of wait states.
module mem_arbiter #(
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic        mem_r_w,
   input  logic [31:0] mem_out,
   output logic        suspend
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] WS_C     = 4'(WAIT_STATES);
   localparam logic       GRANT_IF = 1'b0;
   localparam logic       GRANT_D  = 1'b1;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        last_grant_r;
   logic        grant_r;
   logic        we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_data_r;
   logic        mem_r_w_r;
   logic [31:0] if_rdata_r;
   logic [31:0] d_rdata_r;
   logic        if_ready_r;
   logic        d_ready_r;

   logic        any_req_s;
   logic        pick_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic        sel_we_s;

   // Choose the port to serve; on a tie the port not served last wins.
   always_comb begin
      any_req_s   = 1'b0;
      pick_s      = GRANT_IF;
      if (if_req && d_req) begin
         any_req_s = 1'b1;
         pick_s    = ~last_grant_r;
      end else if (d_req) begin
         any_req_s = 1'b1;
         pick_s    = GRANT_D;
      end else if (if_req) begin
         any_req_s = 1'b1;
         pick_s    = GRANT_IF;
      end else begin
         any_req_s = 1'b0;
         pick_s    = GRANT_IF;
      end
      sel_addr_s  = (pick_s == GRANT_D) ? d_addr : if_addr;
      sel_wdata_s = (pick_s == GRANT_D) ? d_wdata : 32'd0;
      sel_we_s    = (pick_s == GRANT_D) & d_we;
   end

   // Access sequencer: grant, wait-state countdown, capture/strobe, response pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         last_grant_r <= GRANT_D;
         grant_r      <= GRANT_IF;
         we_r         <= 1'b0;
         mem_addr_r   <= 32'd0;
         mem_data_r   <= 32'd0;
         mem_r_w_r    <= 1'b0;
         if_rdata_r   <= 32'd0;
         d_rdata_r    <= 32'd0;
         if_ready_r   <= 1'b0;
         d_ready_r    <= 1'b0;
      end else begin
         if_ready_r <= 1'b0;
         d_ready_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  state_r      <= ACCESS;
                  grant_r      <= pick_s;
                  last_grant_r <= pick_s;
                  we_r         <= sel_we_s;
                  cnt_r        <= WS_C;
                  mem_addr_r   <= sel_addr_s;
                  mem_data_r   <= sel_wdata_s;
                  // With no wait states the first ACCESS cycle is also the last.
                  mem_r_w_r    <= sel_we_s && (WS_C == 4'd0);
               end else begin
                  state_r    <= IDLE;
                  mem_addr_r <= 32'd0;
                  mem_data_r <= 32'd0;
                  mem_r_w_r  <= 1'b0;
               end
            end
            ACCESS: begin
               if (cnt_r == 4'd0) begin
                  state_r    <= RESP;
                  mem_r_w_r  <= 1'b0;
                  mem_addr_r <= 32'd0;
                  mem_data_r <= 32'd0;
                  if (grant_r == GRANT_D) begin
                     d_ready_r <= 1'b1;
                     if (!we_r) begin
                        d_rdata_r <= mem_out;
                     end
                  end else begin
                     if_ready_r <= 1'b1;
                     if_rdata_r <= mem_out;
                  end
               end else begin
                  cnt_r     <= cnt_r - 4'd1;
                  mem_r_w_r <= we_r && (cnt_r == 4'd1);
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r    <= IDLE;
               mem_r_w_r  <= 1'b0;
               mem_addr_r <= 32'd0;
               mem_data_r <= 32'd0;
            end
         endcase
      end
   end

   assign mem_addr = mem_addr_r;
   assign mem_data = mem_data_r;
   assign mem_r_w  = mem_r_w_r;
   assign if_rdata = if_rdata_r;
   assign d_rdata  = d_rdata_r;
   assign if_ready = if_ready_r;
   assign d_ready  = d_ready_r;
   assign suspend  = (if_req & ~if_ready_r) | (d_req & ~d_ready_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: three arbiters (WAIT_STATES 1, 0, 3) driven by random and
// directed masters, compared cycle by cycle against a transaction-timeline model.
module tb_mem_arbiter;

   localparam int NI = 3;
   localparam int WS_TBL [NI] = '{1, 0, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset    [NI];
   logic        if_req   [NI];
   logic [31:0] if_addr  [NI];
   logic [31:0] if_rdata [NI];
   logic        if_ready [NI];
   logic        d_req    [NI];
   logic        d_we     [NI];
   logic [31:0] d_addr   [NI];
   logic [31:0] d_wdata  [NI];
   logic [31:0] d_rdata  [NI];
   logic        d_ready  [NI];
   logic [31:0] mem_addr [NI];
   logic [31:0] mem_data [NI];
   logic        mem_r_w  [NI];
   logic [31:0] mem_out  [NI];
   logic        suspend  [NI];

   int n_chk = 0;
   int n_err = 0;

   // Memory contents as a pure function of address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_arbiter #(.WAIT_STATES(WS_TBL[g])) u_dut (
         .clk      (clk),
         .reset    (reset[g]),
         .if_req   (if_req[g]),
         .if_addr  (if_addr[g]),
         .if_rdata (if_rdata[g]),
         .if_ready (if_ready[g]),
         .d_req    (d_req[g]),
         .d_we     (d_we[g]),
         .d_addr   (d_addr[g]),
         .d_wdata  (d_wdata[g]),
         .d_rdata  (d_rdata[g]),
         .d_ready  (d_ready[g]),
         .mem_addr (mem_addr[g]),
         .mem_data (mem_data[g]),
         .mem_r_w  (mem_r_w[g]),
         .mem_out  (mem_out[g]),
         .suspend  (suspend[g])
      );
      assign mem_out[g] = memf(mem_addr[g]);
   end

   // Model / master state for the instance under test
   int          sel, ws, pct, cyc, t_s, n_rdy;
   bit          active, last, g_port, g_we, chk_rr;
   logic [31:0] g_addr, g_wdata, e_if_rdata, e_d_rdata;
   bit          ip, dp, dwe;
   logic [31:0] ia, da, dw;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (inst %0d, cycle %0d)", tag, obs, exp, sel, cyc);
      end
   endtask

   // One clock cycle: drive masters, predict, compare, advance the model.
   task automatic step(input bit rst_now);
      int k;
      bit was_free, e_ifr, e_dr, e_rw, in_acc;
      k = 0; e_ifr = 1'b0; e_dr = 1'b0; e_rw = 1'b0; in_acc = 1'b0;
      @(posedge clk); #1;
      if (rst_now) begin
         ip = 1'b0; dp = 1'b0;
      end else begin
         if (!ip && $urandom_range(99) < pct) begin
            ip = 1'b1; ia = $urandom;
         end
         if (!dp && $urandom_range(99) < pct) begin
            dp = 1'b1; da = $urandom; dw = $urandom; dwe = ($urandom_range(1) != 0);
         end
      end
      reset[sel] = rst_now;   if_req[sel] = ip;  if_addr[sel] = ia;
      d_req[sel] = dp;        d_we[sel] = dwe;   d_addr[sel] = da;  d_wdata[sel] = dw;

      // A request sampled in cycle t_s occupies cycles t_s+1..t_s+ws+1 and completes at t_s+ws+2.
      was_free = !active;
      if (active) begin
         k = cyc - t_s;
         if (k >= 1 && k <= ws + 1) begin
            in_acc = 1'b1;
            e_rw   = g_port && g_we && (k == ws + 1);
         end
         if (k == ws + 2) begin
            if (g_port) begin
               e_dr = 1'b1;
               if (!g_we) e_d_rdata = memf(g_addr);
            end else begin
               e_ifr = 1'b1;
               e_if_rdata = memf(g_addr);
            end
         end
      end

      @(negedge clk);
      check_eq("if_ready", 32'(if_ready[sel]), 32'(e_ifr));
      check_eq("d_ready",  32'(d_ready[sel]),  32'(e_dr));
      check_eq("mem_r_w",  32'(mem_r_w[sel]),  32'(e_rw));
      check_eq("suspend",  32'(suspend[sel]),  32'((ip & ~e_ifr) | (dp & ~e_dr)));
      check_eq("if_rdata", if_rdata[sel], e_if_rdata);
      check_eq("d_rdata",  d_rdata[sel],  e_d_rdata);
      if (in_acc) begin
         check_eq("mem_addr_acc", mem_addr[sel], g_addr);
         if (g_port && g_we) check_eq("mem_data_acc", mem_data[sel], g_wdata);
      end else if (was_free) begin
         check_eq("mem_addr_idle", mem_addr[sel], 32'd0);
         check_eq("mem_data_idle", mem_data[sel], 32'd0);
      end
      if (chk_rr && (if_ready[sel] || d_ready[sel])) begin
         check_eq("rr_order", 32'(d_ready[sel]), 32'(n_rdy % 2));
         n_rdy++;
      end

      if (rst_now) begin
         active = 1'b0; last = 1'b1; e_if_rdata = 32'd0; e_d_rdata = 32'd0;
      end else if (was_free && (ip || dp)) begin
         g_port  = (ip && dp) ? ~last : dp;
         last    = g_port;
         active  = 1'b1;
         t_s     = cyc;
         g_addr  = g_port ? da : ia;
         g_we    = g_port & dwe;
         g_wdata = dw;
      end else if (!was_free && k == ws + 2) begin
         active = 1'b0;
      end
      if (e_ifr) ip = 1'b0;
      if (e_dr)  dp = 1'b0;
      cyc++;
   endtask

   task automatic start_inst(input int s);
      reset[sel] = 1'b1; if_req[sel] = 1'b0; d_req[sel] = 1'b0;
      sel = s; ws = WS_TBL[s]; cyc = 0; active = 1'b0; last = 1'b1;
      e_if_rdata = 32'd0; e_d_rdata = 32'd0;
      ip = 1'b0; dp = 1'b0; dwe = 1'b0; ia = 32'd0; da = 32'd0; dw = 32'd0;
      pct = 0; chk_rr = 1'b0; n_rdy = 0;
      step(1'b1);
      step(1'b1);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         reset[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = 32'd0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 32'd0; d_wdata[i] = 32'd0;
      end
      sel = 0;

      // WAIT_STATES=1: single fetch at 0x10
      start_inst(0);
      ip = 1'b1; ia = 32'h0000_0010;
      repeat (6) step(1'b0);
      check_eq("fetch_0x10_rdata", if_rdata[0], 32'h0050_0093);

      // Both ports requesting continuously from reset: strict alternation
      start_inst(0);
      pct = 100; chk_rr = 1'b1;
      repeat (32) step(1'b0);
      check_eq("rr_grant_count", 32'(n_rdy), 32'd8);
      chk_rr = 1'b0; pct = 0;
      repeat (12) step(1'b0);
      pct = 35;
      repeat (300) step(1'b0);

      // WAIT_STATES=0: one store, then back-to-back loads
      start_inst(1);
      dp = 1'b1; dwe = 1'b1; da = 32'h0000_0040; dw = 32'hDEAD_BEEF;
      repeat (5) step(1'b0);
      check_eq("store_keeps_d_rdata", d_rdata[1], 32'd0);
      for (int i = 0; i < 18; i++) begin
         if (!dp) begin
            dp = 1'b1; dwe = 1'b0; da = $urandom;
         end
         step(1'b0);
      end
      repeat (4) step(1'b0);
      pct = 35;
      repeat (300) step(1'b0);

      // WAIT_STATES=3: reset during the first ACCESS cycle of a store
      start_inst(2);
      dp = 1'b1; dwe = 1'b1; da = 32'h0000_0080; dw = 32'h1234_5678;
      step(1'b0);
      step(1'b1);
      repeat (8) step(1'b0);
      check_eq("abort_d_rdata", d_rdata[2], 32'd0);
      pct = 35;
      repeat (300) step(1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
